// File: rtl/golomb_diff_checker.sv
// Purpose : checks one candidate ruler of NMARKS marks for the Golomb property (all pair differences distinct).
// Latency : accept at edge k; res_valid at k+1 (order error), k+2+p (first repeat at pair p), k+1+P (clean ruler).
// Backpres: cand_ready only in IDLE, so a held candidate waits; the result is held stable until res_valid && res_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   cand_marks/cand_valid/cand_ready  candidate in, mark k at [k*WIDTH +: WIDTH]
//   res_valid/res_ready               result handshake
//   res_golomb, res_order_err, res_length, res_fail_i, res_fail_j   result fields
//   stat_checked, stat_golomb         delivered-result counters
// Optional feature: define GOLOMB_STATS_EN to build the saturating stat_* counters;
// otherwise stat_* are tied to zero and no counter flops exist.
module golomb_diff_checker #(
    parameter int NMARKS = 5,
    parameter int WIDTH  = 6,
    parameter int IDXW   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NMARKS*WIDTH-1:0] cand_marks,
    input  logic                    cand_valid,
    output logic                    cand_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_golomb,
    output logic                    res_order_err,
    output logic [WIDTH-1:0]        res_length,
    output logic [IDXW-1:0]         res_fail_i,
    output logic [IDXW-1:0]         res_fail_j,
    output logic [15:0]             stat_checked,
    output logic [15:0]             stat_golomb
);

    localparam int DEPTH = 1 << WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  cand_m [NMARKS];
    logic [WIDTH-1:0]  marks  [NMARKS];
    logic [DEPTH-1:0]  bitmap;
    logic [IDXW-1:0]   pi;
    logic [IDXW-1:0]   pj;

    logic              order_bad;
    logic [WIDTH-1:0]  cur_d;
    logic              hit;
    logic              row_end;
    logic              last_pair;
    logic              accept;

    // Unpack the incoming candidate and check strict ascending order of neighbours.
    // Strict order on adjacent marks implies every later difference is non-zero,
    // so bitmap[0] is never touched during CHECK.
    always_comb begin
        order_bad = 1'b0;
        for (int k = 0; k < NMARKS; k++) begin
            cand_m[k] = cand_marks[k*WIDTH +: WIDTH];
        end
        for (int k = 0; k < NMARKS - 1; k++) begin
            if (cand_m[k+1] <= cand_m[k]) begin
                order_bad = 1'b1;
            end
        end
    end

    assign cur_d     = marks[pj] - marks[pi];
    assign hit       = bitmap[cur_d];
    assign row_end   = (pj == IDXW'(NMARKS - 1));
    assign last_pair = (pi == IDXW'(NMARKS - 2)) && row_end;
    assign accept    = (state == IDLE) && cand_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cand_ready = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                cand_ready = 1'b1;
                if (cand_valid) begin
                    state_nxt = order_bad ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (hit || last_pair) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: marks, pair walk, seen-difference bitmap and result fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NMARKS; k++) begin
                marks[k] <= '0;
            end
            bitmap        <= '0;
            pi            <= '0;
            pj            <= '0;
            res_golomb    <= 1'b0;
            res_order_err <= 1'b0;
            res_length    <= '0;
            res_fail_i    <= '0;
            res_fail_j    <= '0;
        end else if (accept) begin
            for (int k = 0; k < NMARKS; k++) begin
                marks[k] <= cand_m[k];
            end
            bitmap        <= '0;
            pi            <= '0;
            pj            <= IDXW'(1);
            res_golomb    <= 1'b0;
            res_order_err <= order_bad;
            // Length is reported even for misordered rulers, wrapping modulo 2**WIDTH.
            res_length    <= cand_m[NMARKS-1] - cand_m[0];
            res_fail_i    <= '0;
            res_fail_j    <= '0;
        end else if (state == CHECK) begin
            if (hit) begin
                res_fail_i <= pi;
                res_fail_j <= pj;
            end else begin
                bitmap[cur_d] <= 1'b1;
                if (last_pair) begin
                    res_golomb <= 1'b1;
                end
            end
            // Walk (0,1),(0,2)..(0,N-1),(1,2).. ; the last row wrap is harmless
            // because the FSM leaves CHECK on the last pair.
            if (row_end) begin
                pi <= pi + IDXW'(1);
                pj <= pi + IDXW'(2);
            end else begin
                pj <= pj + IDXW'(1);
            end
        end
    end

`ifdef GOLOMB_STATS_EN
    logic [15:0] checked_q;
    logic [15:0] golomb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checked_q <= '0;
            golomb_q  <= '0;
        end else if (res_valid && res_ready) begin
            if (checked_q != 16'hFFFF) begin
                checked_q <= checked_q + 16'd1;
            end
            if (res_golomb && (golomb_q != 16'hFFFF)) begin
                golomb_q <= golomb_q + 16'd1;
            end
        end
    end

    assign stat_checked = checked_q;
    assign stat_golomb  = golomb_q;
`else
    assign stat_checked = 16'h0;
    assign stat_golomb  = 16'h0;
`endif

endmodule

// File: tb/tb_golomb_diff_checker.sv
// Scoreboard bench for golomb_diff_checker: stimulus pushes the expected result
// (computed from the ruler rules), a monitor pops and compares whenever a result appears.
module tb_golomb_diff_checker;

    localparam int N = 5;
    localparam int W = 6;

    logic          clk;
    logic          reset;
    logic [N*W-1:0] cand_marks;
    logic          cand_valid;
    logic          cand_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_golomb;
    logic          res_order_err;
    logic [W-1:0]  res_length;
    logic [2:0]    res_fail_i;
    logic [2:0]    res_fail_j;
    logic [15:0]   stat_checked;
    logic [15:0]   stat_golomb;

    golomb_diff_checker #(.NMARKS(N), .WIDTH(W), .IDXW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .cand_marks   (cand_marks),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_golomb   (res_golomb),
        .res_order_err(res_order_err),
        .res_length   (res_length),
        .res_fail_i   (res_fail_i),
        .res_fail_j   (res_fail_j),
        .stat_checked (stat_checked),
        .stat_golomb  (stat_golomb)
    );

    typedef struct {
        bit golomb;
        bit oe;
        int len;
        int fi;
        int fj;
        int lat;
        int acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rand_ready = 0;
    int   stall_next = 0;
    int   hold_cnt = 0;
    int   last_hs = -1;
    int   mdl_checked = 0;
    int   mdl_golomb = 0;
    int   snap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input int a, input int b, input int c, input int d, input int e);
        logic [N*W-1:0] v;
        v = {W'(e), W'(d), W'(c), W'(b), W'(a)};
        return v;
    endfunction

    // Reference: rules of a Golomb ruler plus the documented timing of each outcome.
    function automatic exp_t model(input logic [N*W-1:0] mk);
        int   m[N];
        bit   used[64];
        exp_t e;
        int   p;
        int   d;
        for (int k = 0; k < N; k++) m[k] = int'(mk[k*W +: W]);
        for (int k = 0; k < 64; k++) used[k] = 0;
        e.golomb = 0; e.oe = 0; e.fi = 0; e.fj = 0; e.acc = 0; e.lat = 0;
        e.len = (m[N-1] - m[0]) & 63;
        for (int k = 0; k < N - 1; k++) if (m[k+1] <= m[k]) e.oe = 1;
        if (e.oe) begin
            e.lat = 1;
        end else begin
            p = 0;
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j < N; j++) begin
                    if (e.lat == 0) begin
                        d = m[j] - m[i];
                        if (used[d]) begin
                            e.fi = i; e.fj = j; e.lat = p + 2;
                        end else begin
                            used[d] = 1;
                        end
                        p++;
                    end
                end
            end
            if (e.lat == 0) begin
                e.golomb = 1;
                e.lat = p + 1;
            end
        end
        return e;
    endfunction

    function automatic int outs();
        return {18'd0, res_golomb, res_order_err, res_length, res_fail_i, res_fail_j};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [N*W-1:0] mk, output int acc);
        int   n;
        exp_t e;
        cand_marks = mk;
        cand_valid = 1'b1;
        acc = -1;
        n = 0;
        while (cand_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cand_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_timeout: cand_ready=%0b required 1", cand_ready);
        end else begin
            e = model(mk);
            e.acc = cyc + 1;
            acc = e.acc;
            q.push_back(e);
        end
        @(negedge clk);
        cand_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || seen) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || seen) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
`ifdef GOLOMB_STATS_EN
        chk({tag, "_stat_checked"}, int'(stat_checked), mdl_checked);
        chk({tag, "_stat_golomb"}, int'(stat_golomb), mdl_golomb);
`else
        chk({tag, "_stat_checked"}, int'(stat_checked), 0);
        chk({tag, "_stat_golomb"}, int'(stat_golomb), 0);
`endif
    endtask

    // Monitor / scoreboard, sampling 2 time units after the falling edge.
    initial begin
        exp_t e;
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                seen = 0;
                hold_cnt = 0;
                mdl_checked = 0;
                mdl_golomb = 0;
            end else begin
                if (res_valid && !seen) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_result: res_valid=1 with no candidate pending");
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc + 1 - e.acc, e.lat);
                        chk("res_golomb", int'(res_golomb), int'(e.golomb));
                        chk("res_order_err", int'(res_order_err), int'(e.oe));
                        chk("res_length", int'(res_length), e.len);
                        chk("res_fail_i", int'(res_fail_i), e.fi);
                        chk("res_fail_j", int'(res_fail_j), e.fj);
                    end
                    seen = 1;
                    snap = outs();
                    hold_cnt = stall_next;
                    stall_next = 0;
                end else if (res_valid) begin
                    chk("res_stable", outs(), snap);
                end
                if (hold_cnt > 0) begin
                    res_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (res_valid) begin
                    chk("cand_ready_in_done", int'(cand_ready), 0);
                    if (res_ready) begin
                        seen = 0;
                        last_hs = cyc + 1;
                        mdl_checked++;
                        if (res_golomb) mdl_golomb++;
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        int acc2;
        int base;
        int r;
        logic [N*W-1:0] mk;
        int m[N];

        cand_marks = '0;
        cand_valid = 1'b0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_cand_ready", int'(cand_ready), 1);
        chk("rst_res_golomb", int'(res_golomb), 0);
        chk("rst_order_err", int'(res_order_err), 0);
        chk("rst_length", int'(res_length), 0);
        chk("rst_fail_i", int'(res_fail_i), 0);
        chk("rst_fail_j", int'(res_fail_j), 0);
        chk("rst_stat_checked", int'(stat_checked), 0);
        chk("rst_stat_golomb", int'(stat_golomb), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Three documented cases back to back.
        send(pack(0, 1, 4, 9, 11), acc);
        send(pack(0, 1, 2, 4, 7), acc);
        send(pack(0, 5, 2, 8, 9), acc);
        drain();
        check_stats("three");

        // Result stall of 5 cycles with the next candidate already waiting.
        stall_next = 5;
        send(pack(0, 2, 7, 8, 11), acc);
        send(pack(0, 1, 4, 10, 12), acc2);
        chk("accept_after_hs", acc2, last_hs + 1);
        chk("stall_duration", last_hs - acc, 11 + 5);
        drain();

        // Reset in the 4th CHECK cycle discards the candidate.
        send(pack(0, 1, 4, 9, 11), acc);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        q.delete();
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_cand_ready", int'(cand_ready), 1);
        chk("midrst_stat_checked", int'(stat_checked), 0);
        @(negedge clk);
        chk("midrst_hold_res_valid", int'(res_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(pack(0, 1, 4, 9, 11), acc);
        drain();
        check_stats("after_rst");

        // Randomized candidates with random result backpressure.
        rand_ready = 1;
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                base = $urandom_range(0, 10);
                m[0] = base;
                for (int k = 1; k < N; k++) m[k] = m[k-1] + $urandom_range(1, 12);
                mk = pack(m[0], m[1], m[2], m[3], m[4]);
            end else if (r == 1) begin
                base = $urandom_range(0, 40);
                case ($urandom_range(0, 3))
                    0: mk = pack(base, base + 1, base + 4, base + 9, base + 11);
                    1: mk = pack(base, base + 2, base + 7, base + 8, base + 11);
                    2: mk = pack(base, base + 3, base + 4, base + 9, base + 11);
                    default: mk = pack(base, base + 1, base + 4, base + 10, base + 12);
                endcase
            end else begin
                mk = N*W'($urandom());
            end
            send(mk, acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        rand_ready = 0;
        check_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
